// File: rtl/b01_pkg.sv
// Shared b01 definitions: packer FSM states, default sizes and the counter helper.
// Also holds the b01 comparator state encodings used by neighbouring blocks.
package b01_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic {
        PK_IDLE    = 1'b0,
        PK_COLLECT = 1'b1
    } pk_state_e;

    localparam logic ST_IDLE    = PK_IDLE;
    localparam logic ST_COLLECT = PK_COLLECT;

    // b01 serial flow comparator state encodings
    localparam logic [2:0] B01_A   = 3'd0;
    localparam logic [2:0] B01_B   = 3'd1;
    localparam logic [2:0] B01_C   = 3'd2;
    localparam logic [2:0] B01_E   = 3'd3;
    localparam logic [2:0] B01_F   = 3'd4;
    localparam logic [2:0] B01_G   = 3'd5;
    localparam logic [2:0] B01_WF0 = 3'd6;
    localparam logic [2:0] B01_WF1 = 3'd7;

    // True when a w-bit counter holding v may still be incremented.
    function automatic logic sat_can_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return v != max_v;
    endfunction

endpackage

// File: rtl/b01_word_fifo.sv
// Small synchronous FIFO for tagged packed words; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module b01_word_fifo #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    // Head reads as zero when nothing is queued so stale entries never leak out.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/b01_outp_packer.sv
// Packs the b01 outp stream LSB-first into tagged words behind a valid/ready FIFO.
// Optional B01_PACKER_OVF_RESYNC_EN: an overflw sample mid-word restarts the word.
module b01_outp_packer
    import b01_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_en,
    input  logic                     outp_in,
    input  logic                     overflw_in,
    output logic [WIDTH-1:0]         word_data,
    output logic                     word_ovf,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic                     state_dbg
);

    // Handshake: a word transfers on any edge where word_valid & word_ready;
    // the head holds steady while word_valid=1 and word_ready=0.

    localparam int unsigned BW = $clog2(WIDTH);

    logic             state;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_q;
    logic             part_ovf;
    logic             resync;
    logic             complete;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    logic [WIDTH:0]   push_word;
    logic [WIDTH:0]   head_word;

`ifdef B01_PACKER_OVF_RESYNC_EN
    assign resync = in_en & overflw_in & (state == ST_COLLECT);
`else
    assign resync = 1'b0;
`endif

    assign complete  = in_en & ~resync & (bit_cnt == BW'(WIDTH - 1));
    assign push_word = {part_ovf | overflw_in, outp_in, shift_q[WIDTH-2:0]};
    assign pop       = word_valid & word_ready;
    assign drop      = complete & fifo_full & ~pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift_q  <= '0;
            part_ovf <= 1'b0;
        end else if (in_en) begin
            if (resync) begin
                // Partial bits are abandoned; this sample opens a fresh word.
                shift_q  <= WIDTH'(outp_in);
                bit_cnt  <= BW'(1);
                part_ovf <= 1'b1;
                state    <= ST_COLLECT;
            end else if (complete) begin
                shift_q  <= '0;
                bit_cnt  <= '0;
                part_ovf <= 1'b0;
                state    <= ST_IDLE;
            end else begin
                shift_q[bit_cnt] <= outp_in;
                bit_cnt          <= bit_cnt + BW'(1);
                part_ovf         <= part_ovf | overflw_in;
                state            <= ST_COLLECT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (drop && sat_can_inc(32'(drop_cnt), CNT_W)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (in_en && overflw_in && sat_can_inc(32'(ovf_cnt), CNT_W)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

    b01_word_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (complete),
        .pop     (pop),
        .wdata   (push_word),
        .rdata   (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign word_valid = ~fifo_empty;
    assign word_ovf   = head_word[WIDTH];
    assign word_data  = head_word[WIDTH-1:0];
    assign state_dbg  = state;

endmodule

// File: tb/tb_b01_outp_packer.sv
// Randomised bench for b01_outp_packer against a queue-based behavioural model.
// Honours B01_PACKER_OVF_RESYNC_EN in the model when the build defines it.
module tb_b01_outp_packer;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int CW   = 8;
    localparam int LW   = $clog2(D) + 1;
    localparam int VW   = 3 + W + LW + 2 * CW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_en = 1'b0;
    logic          outp_in = 1'b0;
    logic          overflw_in = 1'b0;
    logic          word_ready = 1'b0;
    logic [W-1:0]  word_data;
    logic          word_ovf;
    logic          word_valid;
    logic [LW-1:0] fifo_level;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] ovf_cnt;
    logic          state_dbg;

    // model state
    logic [W:0] exp_q[$];
    logic       pbits[$];
    logic       pflag;
    int         exp_drop;
    int         exp_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    b01_outp_packer #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_en      (in_en),
        .outp_in    (outp_in),
        .overflw_in (overflw_in),
        .word_data  (word_data),
        .word_ovf   (word_ovf),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .ovf_cnt    (ovf_cnt),
        .state_dbg  (state_dbg)
    );

    function automatic logic [VW-1:0] obs_vec();
        return {state_dbg, word_valid, word_ovf, word_data, fifo_level, drop_cnt, ovf_cnt};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [W:0] head;
        head = '0;
        if (exp_q.size() > 0) head = exp_q[0];
        return {logic'(pbits.size() != 0), logic'(exp_q.size() != 0), head[W], head[W-1:0],
                LW'(exp_q.size()), CW'(exp_drop), CW'(exp_ovf)};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        pbits.delete();
        pflag    = 1'b0;
        exp_drop = 0;
        exp_ovf  = 0;
    endtask

    // One clock edge of behaviour: pop the head, then apply the sample.
    task automatic model_step(input logic en, input logic o, input logic ov, input logic rdy);
        logic [W:0] w;
        if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
        if (en) begin
            if (ov && exp_ovf < CMAX) exp_ovf++;
`ifdef B01_PACKER_OVF_RESYNC_EN
            if (ov && pbits.size() > 0) begin
                pbits.delete();
                pflag = 1'b0;
            end
`endif
            pbits.push_back(o);
            pflag = pflag | ov;
            if (pbits.size() == W) begin
                w = '0;
                for (int i = 0; i < W; i++) w[i] = pbits[i];
                w[W] = pflag;
                pbits.delete();
                pflag = 1'b0;
                if (exp_q.size() < D) exp_q.push_back(w);
                else if (exp_drop < CMAX) exp_drop++;
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are inspected at the next falling edge.
    task automatic drive(input logic en, input logic o, input logic ov, input logic rdy);
        in_en      = en;
        outp_in    = o;
        overflw_in = ov;
        word_ready = rdy;
        @(posedge clock);
        model_step(en, o, ov, rdy);
        @(negedge clock);
    endtask

    task automatic do_reset();
        in_en = 1'b0; outp_in = 1'b0; overflw_in = 1'b0; word_ready = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        in_en = 1'b0; outp_in = 1'b0; overflw_in = 1'b0; word_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'h4D;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[i], 1'b0, 1'b1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            n_checks++;
            if (word_valid !== (i == 7)) begin
                n_fail++;
                $display("FAIL basic_valid_cyc%0d: got %b expected %b", i, word_valid, i == 7);
            end
        end
        n_checks++;
        if ({word_ovf, word_data} !== 9'h04D) begin
            n_fail++;
            $display("FAIL basic_word: got %h expected 04d", {word_ovf, word_data});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_popped: got %b expected 0", word_valid);
        end
    endtask

    task automatic test_ovf_mid();
        logic [7:0] pat;
        pat = 8'h4D;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[i], logic'(i == 2), 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_mid_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
`ifdef B01_PACKER_OVF_RESYNC_EN
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_resync_nopush: got %b expected 0", word_valid);
        end
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({word_valid, word_ovf, word_data[0]} !== 3'b111) begin
            n_fail++;
            $display("FAIL ovf_resync_word: got %b expected 111", {word_valid, word_ovf, word_data[0]});
        end
`else
        n_checks++;
        if ({word_valid, word_ovf, word_data, ovf_cnt} !== {1'b1, 1'b1, 8'h4D, 8'd1}) begin
            n_fail++;
            $display("FAIL ovf_flag_word: got %h expected %h", {word_valid, word_ovf, word_data, ovf_cnt},
                     {1'b1, 1'b1, 8'h4D, 8'd1});
        end
`endif
    endtask

    task automatic test_drop_full();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drop_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({fifo_level, word_data, drop_cnt} !== {LW'(4), 8'hFF, 8'd1}) begin
            n_fail++;
            $display("FAIL drop_state: got %h expected %h", {fifo_level, word_data, drop_cnt},
                     {LW'(4), 8'hFF, 8'd1});
        end
        // full FIFO, completing sample coincides with a pop
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, logic'(i == 7));
        n_checks++;
        if ({fifo_level, drop_cnt} !== {LW'(4), 8'd1}) begin
            n_fail++;
            $display("FAIL full_pop: got %h expected %h", {fifo_level, drop_cnt}, {LW'(4), 8'd1});
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_gapped();
        logic [7:0] pat;
        pat = 8'h4D;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[i], 1'b0, 1'b0);
            if (i < 7) begin
                drive(1'b0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b0);
                drive(1'b0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b0);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL gapped_bit%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({word_valid, word_ovf, word_data, ovf_cnt} !== {1'b1, 1'b0, 8'h4D, 8'd0}) begin
            n_fail++;
            $display("FAIL gapped_word: got %h expected %h", {word_valid, word_ovf, word_data, ovf_cnt},
                     {1'b1, 1'b0, 8'h4D, 8'd0});
        end
    endtask

    task automatic test_random();
        logic en, o, ov, rdy;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            en  = logic'($urandom_range(0, 3) != 0);
            o   = logic'($urandom_range(0, 1));
            ov  = logic'($urandom_range(0, 9) == 0);
            rdy = logic'($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 2 : 8));
            drive(en, o, ov, rdy);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 2100; i++) begin
            drive(1'b1, logic'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (obs_vec() !== exp_vec()) bad++;
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, logic'($urandom_range(0, 1)), 1'b1, 1'b0);
            if (obs_vec() !== exp_vec()) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sat_trace: got %0d differing cycles expected 0", bad);
        end
        n_checks++;
        if ({drop_cnt, ovf_cnt} !== {8'hFF, 8'hFF}) begin
            n_fail++;
            $display("FAIL sat_counters: got %h expected ffff", {drop_cnt, ovf_cnt});
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] pat;
        do_reset();
        for (int i = 0; i < 21; i++) drive(1'b1, logic'($urandom_range(0, 1)), logic'(i == 3), 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL arst_pre: got %h expected %h", obs_vec(), exp_vec());
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL arst_clear: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        model_clear();
        in_en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pat = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) drive(1'b1, pat[i], 1'b0, 1'b0);
        n_checks++;
        if ({word_valid, word_ovf, word_data, fifo_level, drop_cnt} !== {1'b1, 1'b0, pat, LW'(1), 8'd0}) begin
            n_fail++;
            $display("FAIL arst_clean_word: got %h expected %h", {word_valid, word_ovf, word_data, fifo_level, drop_cnt},
                     {1'b1, 1'b0, pat, LW'(1), 8'd0});
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_ovf_mid();
        test_drop_full();
        test_gapped();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
